// File: rtl/oven_timer_ctrl_if.sv
// Timer-side bus of the oven sequencer: BCD preset, load/clear strobes, enable and zero flag.
// The controller uses the master modport; the down-counter timer uses the slave modport.
interface oven_timer_ctrl_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] timer_data;
  logic              timer_loadn;
  logic              timer_clearn;
  logic              timer_en;
  logic              timer_zero;

  modport master (
    output timer_data,
    output timer_loadn,
    output timer_clearn,
    output timer_en,
    input  timer_zero
  );

  modport slave (
    input  timer_data,
    input  timer_loadn,
    input  timer_clearn,
    input  timer_en,
    output timer_zero
  );
endinterface

// File: rtl/oven_timer_ctrl.sv
// Microwave oven top-level sequencer: keypad entry, timer load/clear/enable,
// magnetron with door interlock, and a fixed-length end-of-cook alarm.
module oven_timer_ctrl #(
  parameter int unsigned NDIG         = 4,
  parameter int unsigned ALARM_CYCLES = 20
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             key_valid,
  input  logic [3:0]       key_digit,
  input  logic             start,
  input  logic             stop,
  input  logic             door_closed,
  oven_timer_ctrl_if.master tmr,
  output logic             mag_on,
  output logic             alarm,
  output logic [2:0]       state
);

  localparam int unsigned EntryW = 4 * NDIG;
  localparam int unsigned CntW   = $clog2(ALARM_CYCLES + 1);
  localparam logic [CntW-1:0] AlarmLoad = CntW'(ALARM_CYCLES);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCook  = 3'd2,
    StPause = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e              state_q;
  logic [EntryW-1:0]   entry_q;
  logic [CntW-1:0]     alarm_cnt_q;
  logic                loadn_q;
  logic                clearn_q;
  logic                en_q;
  logic                mag_q;
  logic                alarm_q;
  logic                blank_q;

  logic                key_ok;
  logic [EntryW+3:0]   entry_ext;
  logic [EntryW-1:0]   entry_shift;

  // New digit enters at the least-significant position; the old MSD falls off the top.
  always_comb begin
    key_ok      = key_valid && (key_digit <= 4'd9);
    entry_ext   = {entry_q, key_digit};
    entry_shift = entry_ext[EntryW-1:0];
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= StIdle;
      entry_q     <= '0;
      alarm_cnt_q <= '0;
      loadn_q     <= 1'b1;
      clearn_q    <= 1'b1;
      en_q        <= 1'b0;
      mag_q       <= 1'b0;
      alarm_q     <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      loadn_q  <= 1'b1;
      clearn_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (stop) begin
            entry_q  <= '0;
            clearn_q <= 1'b0;
          end else if (start && door_closed && (entry_q != '0)) begin
            state_q <= StLoad;
            loadn_q <= 1'b0;
          end else if (key_ok) begin
            entry_q <= entry_shift;
          end
        end

        StLoad: begin
          state_q <= StCook;
          en_q    <= 1'b1;
          mag_q   <= 1'b1;
          blank_q <= 1'b1;
        end

        StCook: begin
          // The timer's zero flag is stale for one edge after a load.
          blank_q <= 1'b0;
          if (!blank_q && tmr.timer_zero) begin
            state_q     <= StDone;
            en_q        <= 1'b0;
            mag_q       <= 1'b0;
            alarm_q     <= 1'b1;
            entry_q     <= '0;
            alarm_cnt_q <= AlarmLoad;
          end else if (!door_closed || stop) begin
            state_q <= StPause;
            en_q    <= 1'b0;
            mag_q   <= 1'b0;
          end
        end

        StPause: begin
          if (stop) begin
            state_q  <= StIdle;
            entry_q  <= '0;
            clearn_q <= 1'b0;
          end else if (start && door_closed) begin
            state_q <= StCook;
            en_q    <= 1'b1;
            mag_q   <= 1'b1;
          end
        end

        StDone: begin
          if (stop || !door_closed || (alarm_cnt_q == CntOne)) begin
            state_q     <= StIdle;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
          end else begin
            alarm_cnt_q <= alarm_cnt_q - CntOne;
          end
        end

        default: begin
          state_q <= StIdle;
          en_q    <= 1'b0;
          mag_q   <= 1'b0;
          alarm_q <= 1'b0;
        end
      endcase
    end
  end

  assign tmr.timer_data   = entry_q;
  assign tmr.timer_loadn  = loadn_q;
  assign tmr.timer_clearn = clearn_q;
  assign tmr.timer_en     = en_q;
  assign mag_on           = mag_q;
  assign alarm            = alarm_q;
  assign state            = state_q;

  strobe_exclusive_a : assert property (@(posedge clk) disable iff (clear)
    !(!loadn_q && !clearn_q));

  mag_only_in_cook_a : assert property (@(posedge clk) disable iff (clear)
    mag_q |-> (state_q == StCook));

endmodule

// File: tb/tb_oven_timer_ctrl.sv
// Bench for oven_timer_ctrl: directed vector table, hand sequences for corner cases,
// and random stimulus compared against a mode-level reference model.
module tb_oven_timer_ctrl;

  localparam int unsigned NDIG         = 4;
  localparam int unsigned ALARM_CYCLES = 20;
  localparam int          NRAND        = 3000;

  localparam int MIdle  = 0;
  localparam int MLoad  = 1;
  localparam int MCook  = 2;
  localparam int MPause = 3;
  localparam int MDone  = 4;

  logic       clk = 1'b0;
  logic       clear;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       start;
  logic       stop;
  logic       door_closed;
  logic       mag_on;
  logic       alarm;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  oven_timer_ctrl_if #(.NDIG(NDIG)) tif ();

  oven_timer_ctrl #(
    .NDIG        (NDIG),
    .ALARM_CYCLES(ALARM_CYCLES)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .start      (start),
    .stop       (stop),
    .door_closed(door_closed),
    .tmr        (tif),
    .mag_on     (mag_on),
    .alarm      (alarm),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        kv;
    bit [3:0]  kd;
    bit        st;
    bit        sp;
    bit        door;
    bit        zero;
    bit [2:0]  e_state;
    bit [15:0] e_data;
    bit        e_loadn;
    bit        e_clearn;
    bit        e_en;
    bit        e_mag;
    bit        e_alarm;
  } vec_t;

  vec_t vecs[16];

  // Reference model: cooking mode plus the keyed digits as plain integers.
  int  m_mode;
  int  m_digits[NDIG];
  bit  m_cleared;
  bit  m_fresh;
  int  m_alarm_elapsed;

  function automatic vec_t mkv(bit kv, bit [3:0] kd, bit st, bit sp, bit door, bit zero,
                               bit [2:0] es, bit [15:0] ed, bit el, bit ec, bit ee, bit em,
                               bit ea);
    vec_t v;
    v.kv = kv; v.kd = kd; v.st = st; v.sp = sp; v.door = door; v.zero = zero;
    v.e_state = es; v.e_data = ed; v.e_loadn = el; v.e_clearn = ec;
    v.e_en = ee; v.e_mag = em; v.e_alarm = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int es, input int ed, input bit el,
                         input bit ec, input bit ee, input bit em, input bit ea);
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".data"}, 32'(tif.timer_data), 32'(ed));
    chk({tag, ".loadn"}, 32'(tif.timer_loadn), 32'(el));
    chk({tag, ".clearn"}, 32'(tif.timer_clearn), 32'(ec));
    chk({tag, ".en"}, 32'(tif.timer_en), 32'(ee));
    chk({tag, ".mag"}, 32'(mag_on), 32'(em));
    chk({tag, ".alarm"}, 32'(alarm), 32'(ea));
  endtask

  task automatic set_in(input bit kv, input bit [3:0] kd, input bit st, input bit sp,
                        input bit door, input bit zero);
    key_valid      = kv;
    key_digit      = kd;
    start          = st;
    stop           = sp;
    door_closed    = door;
    tif.timer_zero = zero;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    set_in(0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", MIdle, 0, 1, 1, 0, 0, 0);
    clear = 1'b0;
  endtask

  task automatic key(input bit [3:0] d);
    set_in(1, d, 0, 0, 1, 0);
    step();
  endtask

  function automatic int m_value();
    int v = 0;
    for (int i = NDIG - 1; i >= 0; i--) v = v * 16 + m_digits[i];
    return v;
  endfunction

  task automatic m_reset();
    m_mode = MIdle;
    for (int i = 0; i < NDIG; i++) m_digits[i] = 0;
    m_cleared = 0;
    m_fresh = 0;
    m_alarm_elapsed = 0;
  endtask

  task automatic m_wipe();
    for (int i = 0; i < NDIG; i++) m_digits[i] = 0;
  endtask

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic m_edge();
    bit fresh;
    m_cleared = 0;
    fresh = m_fresh;
    m_fresh = 0;
    case (m_mode)
      MIdle: begin
        if (stop) begin
          m_wipe();
          m_cleared = 1;
        end else if (start && door_closed && m_value() != 0) begin
          m_mode = MLoad;
        end else if (key_valid && key_digit < 10) begin
          for (int i = NDIG - 1; i > 0; i--) m_digits[i] = m_digits[i-1];
          m_digits[0] = int'(key_digit);
        end
      end
      MLoad: begin
        m_mode = MCook;
        m_fresh = 1;
      end
      MCook: begin
        if (!fresh && tif.timer_zero) begin
          m_mode = MDone;
          m_wipe();
          m_alarm_elapsed = 0;
        end else if (!door_closed || stop) begin
          m_mode = MPause;
        end
      end
      MPause: begin
        if (stop) begin
          m_mode = MIdle;
          m_wipe();
          m_cleared = 1;
        end else if (start && door_closed) begin
          m_mode = MCook;
        end
      end
      default: begin
        m_alarm_elapsed++;
        if (stop || !door_closed || m_alarm_elapsed == ALARM_CYCLES) m_mode = MIdle;
      end
    endcase
  endtask

  initial begin
    clear = 1'b1;
    set_in(0, 0, 0, 0, 1, 0);

    // Key entry, cancel, empty start, then a full cook into DONE.
    vecs[0]  = mkv(1, 4'd1,  0, 0, 1, 0, MIdle, 16'h0001, 1, 1, 0, 0, 0);
    vecs[1]  = mkv(1, 4'd2,  0, 0, 1, 0, MIdle, 16'h0012, 1, 1, 0, 0, 0);
    vecs[2]  = mkv(1, 4'd3,  0, 0, 1, 0, MIdle, 16'h0123, 1, 1, 0, 0, 0);
    vecs[3]  = mkv(1, 4'd4,  0, 0, 1, 0, MIdle, 16'h1234, 1, 1, 0, 0, 0);
    vecs[4]  = mkv(1, 4'd11, 0, 0, 1, 0, MIdle, 16'h1234, 1, 1, 0, 0, 0);
    vecs[5]  = mkv(1, 4'd5,  0, 0, 1, 0, MIdle, 16'h2345, 1, 1, 0, 0, 0);
    vecs[6]  = mkv(0, 4'd0,  0, 0, 1, 0, MIdle, 16'h2345, 1, 1, 0, 0, 0);
    vecs[7]  = mkv(1, 4'd7,  1, 1, 1, 0, MIdle, 16'h0000, 1, 0, 0, 0, 0);
    vecs[8]  = mkv(0, 4'd0,  0, 0, 1, 0, MIdle, 16'h0000, 1, 1, 0, 0, 0);
    vecs[9]  = mkv(0, 4'd0,  1, 0, 1, 0, MIdle, 16'h0000, 1, 1, 0, 0, 0);
    vecs[10] = mkv(1, 4'd5,  0, 0, 1, 0, MIdle, 16'h0005, 1, 1, 0, 0, 0);
    vecs[11] = mkv(0, 4'd0,  1, 0, 1, 0, MLoad, 16'h0005, 0, 1, 0, 0, 0);
    vecs[12] = mkv(1, 4'd9,  0, 0, 1, 1, MCook, 16'h0005, 1, 1, 1, 1, 0);
    vecs[13] = mkv(0, 4'd0,  0, 0, 1, 1, MCook, 16'h0005, 1, 1, 1, 1, 0);
    vecs[14] = mkv(0, 4'd0,  0, 0, 1, 0, MCook, 16'h0005, 1, 1, 1, 1, 0);
    vecs[15] = mkv(0, 4'd0,  0, 0, 1, 1, MDone, 16'h0000, 1, 1, 0, 0, 1);

    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(vecs[i].kv, vecs[i].kd, vecs[i].st, vecs[i].sp, vecs[i].door, vecs[i].zero);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_data, vecs[i].e_loadn,
              vecs[i].e_clearn, vecs[i].e_en, vecs[i].e_mag, vecs[i].e_alarm);
    end

    // Alarm lasts exactly ALARM_CYCLES cycles (the first was checked by vec15).
    set_in(0, 0, 0, 0, 1, 0);
    for (int i = 1; i < ALARM_CYCLES; i++) begin
      step();
      chk_all($sformatf("alarm%0d", i), MDone, 0, 1, 1, 0, 0, 1);
    end
    step();
    chk_all("alarm_end", MIdle, 0, 1, 1, 0, 0, 0);

    // Door interlock: pause on open door, resume without reload or blanking.
    key(4'd3);
    set_in(0, 0, 1, 0, 1, 0); step();
    chk_all("door.load", MLoad, 16'h0003, 0, 1, 0, 0, 0);
    set_in(0, 0, 0, 0, 1, 0); step();
    step();
    chk_all("door.cook", MCook, 16'h0003, 1, 1, 1, 1, 0);
    set_in(0, 0, 0, 0, 0, 0); step();
    chk_all("door.open", MPause, 16'h0003, 1, 1, 0, 0, 0);
    set_in(0, 0, 1, 0, 0, 0); step();
    chk_all("door.start_open", MPause, 16'h0003, 1, 1, 0, 0, 0);
    set_in(0, 0, 1, 0, 1, 0); step();
    chk_all("door.resume", MCook, 16'h0003, 1, 1, 1, 1, 0);
    set_in(0, 0, 0, 0, 1, 1); step();
    chk_all("door.no_blank", MDone, 0, 1, 1, 0, 0, 1);
    set_in(0, 0, 0, 1, 1, 0); step();
    chk_all("door.alarm_stop", MIdle, 0, 1, 1, 0, 0, 0);

    // Cancel from PAUSE clears the entry and pulses clearn once.
    key(4'd7);
    set_in(0, 0, 1, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    set_in(0, 0, 0, 1, 1, 0); step();
    chk_all("cancel.pause", MPause, 16'h0007, 1, 1, 0, 0, 0);
    step();
    chk_all("cancel.idle", MIdle, 0, 1, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 1, 0); step();
    chk_all("cancel.after", MIdle, 0, 1, 1, 0, 0, 0);

    // Zero wins over stop and open door; stop at alarm cycle 3 ends the alarm.
    key(4'd9);
    set_in(0, 0, 1, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    step();
    set_in(0, 0, 0, 1, 0, 1); step();
    chk_all("simul.done", MDone, 0, 1, 1, 0, 0, 1);
    set_in(0, 0, 0, 0, 1, 0); step();
    step();
    chk_all("simul.cyc3", MDone, 0, 1, 1, 0, 0, 1);
    set_in(0, 0, 0, 1, 1, 0); step();
    chk_all("simul.stop", MIdle, 0, 1, 1, 0, 0, 0);

    // Asynchronous reset between edges while cooking.
    key(4'd2);
    set_in(0, 0, 1, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 1, 0); step();
    chk_all("async.cook", MCook, 16'h0002, 1, 1, 1, 1, 0);
    #2 clear = 1'b1;
    #1 chk_all("async.hit", MIdle, 0, 1, 1, 0, 0, 0);
    #1 clear = 1'b0;
    step();
    chk_all("async.wait", MIdle, 0, 1, 1, 0, 0, 0);

    // Random stimulus against the reference model.
    do_reset();
    m_reset();
    for (int n = 0; n < NRAND; n++) begin
      bit st;
      bit kv;
      st = ($urandom_range(0, 99) < 20);
      kv = !st && ($urandom_range(0, 99) < 35);
      set_in(kv, 4'($urandom_range(0, 15)), st, ($urandom_range(0, 99) < 7),
             ($urandom_range(0, 99) < 90), ($urandom_range(0, 99) < 15));
      m_edge();
      step();
      chk_all($sformatf("rand%0d", n), m_mode, m_value(), (m_mode != MLoad), !m_cleared,
              (m_mode == MCook), (m_mode == MCook), (m_mode == MDone));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oven_timer_ctrl.md
Name: oven_timer_ctrl

Overview:
- Control FSM that drives the microwave down-counter timer from the initiating side.
- Collects keypad digits into a BCD cook-time register and presents it on the timer's data inputs.
- Issues the timer's load, clear and enable strobes, and consumes the timer's zero flag.
- Runs the magnetron, door interlock and end-of-cook alarm; it is the top-level sequencer above the timer in the microondas hierarchy.

Parameters:
- NDIG, 4, number of BCD digits in the cook-time register (mm:ss at default); timer_data width is 4*NDIG.
- ALARM_CYCLES, 20, number of clk cycles alarm stays high after cooking completes; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clear  input  1  asynchronous reset, active-high.
- key_valid  input  1  one-cycle strobe: key_digit is valid this cycle.
- key_digit  input  4  keypad code; 0-9 are accepted, 10-15 are ignored.
- start  input  1  start/resume request, level-sampled each cycle.
- stop  input  1  pause/cancel request, level-sampled each cycle.
- door_closed  input  1  1 = door closed.
- timer_zero  input  1  zero flag from the timer.
- timer_data  output  4*NDIG  BCD cook time; digit 0 is the least-significant second.
- timer_loadn  output  1  active-low load strobe to the timer.
- timer_clearn  output  1  active-low clear strobe to the timer.
- timer_en  output  1  timer count enable.
- mag_on  output  1  magnetron enable.
- alarm  output  1  end-of-cook alarm.
- state  output  3  current state: IDLE=0, LOAD=1, COOK=2, PAUSE=3, DONE=4.

Behaviour:
- Reset (clear=1, asynchronous):
  - state=IDLE, entry register=0, timer_loadn=1, timer_clearn=1, timer_en=0, mag_on=0, alarm=0, alarm counter=0.
  - Reset applies immediately, including mid-COOK; no strobes are issued on reset.
- All outputs are registered. timer_data always equals the entry register.
- IDLE:
  - key_valid with key_digit<=9: shift entry left one digit, new digit into digit 0, old MSD discarded. key_digit>9 causes no change.
  - stop: entry<=0 and timer_clearn=0 for exactly one cycle. stop takes priority over key_valid and start in the same cycle.
  - start with door_closed=1 and entry!=0: go to LOAD. Otherwise start is ignored.
- LOAD (exactly one cycle):
  - timer_loadn=0 this cycle only; next state COOK.
  - Inputs are ignored.
- COOK:
  - timer_en=1, mag_on=1.
  - timer_zero is blanked in the first COOK cycle after LOAD, because the zero flag updates one edge after load.
  - After blanking, timer_zero=1 goes to DONE. This takes priority over stop and door open in the same cycle.
  - Otherwise, door_closed=0 or stop=1 goes to PAUSE.
  - key_valid is ignored.
- PAUSE:
  - timer_en=0, mag_on=0; the timer holds its count and entry is unchanged.
  - stop: go to IDLE, entry<=0, timer_clearn=0 for one cycle.
  - Otherwise start with door_closed=1: back to COOK with no reload and no blanking cycle.
  - start with the door open is ignored. key_valid is ignored.
- DONE:
  - On entry: timer_en=0, mag_on=0, alarm=1, entry<=0, alarm counter loaded with ALARM_CYCLES.
  - alarm stays high for exactly ALARM_CYCLES cycles, then the FSM goes to IDLE with alarm=0.
  - stop or door_closed=0 ends the alarm early: IDLE on the next edge.
  - start and keys are ignored.
- Strobes:
  - timer_loadn and timer_clearn are never low in the same cycle.
  - Each strobe is low for exactly one cycle per request, even if stop or start is held; a held stop in IDLE re-issues the clear each cycle (harmless).
- mag_on is 1 only in COOK. It must drop on the edge after door_closed falls.

Test Plan:
- Key entry and full load: reset; keys 1,2,3,4 as single-cycle strobes -> timer_data=16'h1234; key 11 -> unchanged; key 5 -> 16'h2345 (MSD dropped).
- Normal cook: entry 16'h0005, door closed, start pulse -> LOAD for one cycle with timer_loadn=0; COOK with timer_en=mag_on=1; zero ignored in the first COOK cycle; zero=1 later -> DONE; alarm=1 for exactly 20 cycles; then IDLE with timer_data=0.
- Door interlock: in COOK, drop door_closed -> PAUSE, mag_on=0 next edge, no loadn pulse; start with door open -> stays PAUSE; close door and start -> COOK with no loadn pulse.
- Cancel: in PAUSE, stop -> IDLE, exactly one-cycle timer_clearn=0, entry=0. In IDLE with entry=0, start -> stays IDLE with no strobes.
- Simultaneous events: in COOK after blanking, zero=1 with stop=1 and door open together -> DONE, not PAUSE. In DONE, stop at alarm cycle 3 -> IDLE with alarm=0.
- Async reset mid-COOK: assert clear between edges -> all outputs at reset values immediately, state=0; release clear -> FSM waits in IDLE.
